// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Word-organised data memory that answers load/store requests from a
//   control unit after a programmable number of wait cycles.
//
//   Parameters
//     WAIT_STATES  extra wait cycles before each access (0..15)
//     DEPTH_WORDS  number of 32-bit storage words
//     BASE_ADDR    byte address of word 0
//
//   Ports
//     Clk     in   sole clock, rising edge
//     Reset   in   synchronous active-high reset
//     Req     in   request strobe, sampled only while idle
//     We      in   1 = store, 0 = load
//     Byte    in   1 = byte access, 0 = word access
//     Addr    in   [31:0] byte address
//     WrData  in   [31:0] store data (byte store uses bits 7:0)
//     Busy    out  high whenever a request is in flight
//     Ack     out  one-cycle completion pulse
//     Err     out  illegal-access flag, only ever high together with Ack
//     RdData  out  [31:0] registered load result
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int          WAIT_STATES = 2,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        We,
  input  logic        Byte,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic        Busy,
  output logic        Ack,
  output logic        Err,
  output logic [31:0] RdData
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Pick little-endian byte lane 'lane' out of a word.
  function automatic logic [7:0] lane_extract(input logic [31:0] word,
                                              input logic [1:0]  lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Replace little-endian byte lane 'lane' of a word, keeping the other lanes.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    case (lane)
      2'd0:    w[7:0]   = b;
      2'd1:    w[15:8]  = b;
      2'd2:    w[23:16] = b;
      2'd3:    w[31:24] = b;
      default: w = word;
    endcase
    return w;
  endfunction

  // Storage is deliberately never reset; contents survive Reset.
  logic [31:0] mem [DEPTH_WORDS];

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        we_r, byte_r;
  logic [31:0] addr_r, wdata_r;
  logic        ack_r, err_r, busy_r;
  logic [31:0] rdata_r;

  logic        access_s;
  logic [31:0] idx_full_s;
  logic [AW-1:0] idx_s;
  logic        err_s;
  logic [31:0] word_s;
  logic [31:0] rd_value_s;
  logic [31:0] merged_s;

  // Next-state and counter logic of the request sequencer.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (Req) begin
          state_s = ST_WAIT;
          cnt_s   = 4'(WAIT_STATES);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r != 4'd0) begin
          cnt_s = cnt_r - 4'd1;
        end else begin
          state_s = ST_RESP;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Address decode, legality check and read/merge data paths.
  always_comb begin
    access_s = (state_r == ST_WAIT) && (cnt_r == 4'd0);
    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    idx_full_s = (addr_r - BASE_ADDR) >> 2;
    idx_s      = idx_full_s[AW-1:0];
    if (idx_full_s >= 32'(DEPTH_WORDS)) begin
      err_s = 1'b1;
    end else if (!byte_r && (addr_r[1:0] != 2'b00)) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
    word_s = mem[idx_s];
    if (byte_r) begin
      rd_value_s = {24'h000000, lane_extract(word_s, addr_r[1:0])};
      merged_s   = lane_merge(word_s, addr_r[1:0], wdata_r[7:0]);
    end else begin
      rd_value_s = word_s;
      merged_s   = wdata_r;
    end
  end

  // Sequencer state, request capture and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      byte_r  <= 1'b0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if ((state_r == ST_IDLE) && Req) begin
        we_r    <= We;
        byte_r  <= Byte;
        addr_r  <= Addr;
        wdata_r <= WrData;
      end
      ack_r  <= access_s;
      err_r  <= access_s & err_s;
      busy_r <= (state_s != ST_IDLE);
      // Load data only moves on a read or a rejected access; stores leave it.
      if (access_s && (err_s || !we_r)) begin
        rdata_r <= err_s ? 32'h0000_0000 : rd_value_s;
      end
    end
  end

  // Storage write port; Reset on the access edge cancels the store.
  always_ff @(posedge Clk) begin
    if (!Reset && access_s && we_r && !err_s) begin
      mem[idx_s] <= merged_s;
    end
  end

  assign Busy   = busy_r;
  assign Ack    = ack_r;
  assign Err    = err_r;
  assign RdData = rdata_r;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  // Instance with two wait states.
  logic        req = 1'b0, we = 1'b0, bt = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        busy, ack, err;
  logic [31:0] rdata;

  // Instance with zero wait states.
  logic        req0 = 1'b0, we0 = 1'b0, bt0 = 1'b0;
  logic [31:0] addr0 = 32'h0, wdata0 = 32'h0;
  logic        busy0, ack0, err0;
  logic [31:0] rdata0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.WAIT_STATES(2), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0400)) dut (
    .Clk(clk), .Reset(reset), .Req(req), .We(we), .Byte(bt), .Addr(addr),
    .WrData(wdata), .Busy(busy), .Ack(ack), .Err(err), .RdData(rdata)
  );

  data_mem_responder #(.WAIT_STATES(0), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0400)) dut0 (
    .Clk(clk), .Reset(reset), .Req(req0), .We(we0), .Byte(bt0), .Addr(addr0),
    .WrData(wdata0), .Busy(busy0), .Ack(ack0), .Err(err0), .RdData(rdata0)
  );

  // Issue one request on the WAIT_STATES=2 instance; lat counts edges from
  // the sampling edge to the edge after which Ack is seen. Returns idle.
  task automatic access(input logic w, input logic b, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic e, output int lat);
    req = 1'b1; we = w; bt = b; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 0;
    while (ack !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata;
    e  = err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (ack !== 1'b0) $display("FAIL reset_ack got %b want 0", ack); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passes++;
    checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata got %h want 00000000", rdata); else passes++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word_rw();
    logic [31:0] rd; logic e; int lat;
    access(1'b1, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF, rd, e, lat);
    checks++; if (lat !== 3) $display("FAIL wr_latency got %0d want 3", lat); else passes++;
    checks++; if (e !== 1'b0) $display("FAIL wr_err got %b want 0", e); else passes++;
    checks++; if (rd !== 32'h0) $display("FAIL wr_rdata_held got %h want 00000000", rd); else passes++;
    checks++; if (ack !== 1'b0 || err !== 1'b0 || busy !== 1'b0)
      $display("FAIL post_ack_idle got ack=%b err=%b busy=%b want 0 0 0", ack, err, busy); else passes++;
    access(1'b0, 1'b0, 32'h0000_0400, 32'h0, rd, e, lat);
    checks++; if (lat !== 3) $display("FAIL rd_latency got %0d want 3", lat); else passes++;
    checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL rd_word got %h want deadbeef", rd); else passes++;
    checks++; if (e !== 1'b0) $display("FAIL rd_err got %b want 0", e); else passes++;
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic e; int lat;
    access(1'b1, 1'b0, 32'h0000_0404, 32'h1122_3344, rd, e, lat);
    access(1'b1, 1'b1, 32'h0000_0405, 32'hFFFF_FFAA, rd, e, lat);
    checks++; if (e !== 1'b0) $display("FAIL byte_wr_err got %b want 0", e); else passes++;
    access(1'b0, 1'b0, 32'h0000_0404, 32'h0, rd, e, lat);
    checks++; if (rd !== 32'h1122_AA44) $display("FAIL byte_merge got %h want 1122aa44", rd); else passes++;
    access(1'b0, 1'b1, 32'h0000_0407, 32'h0, rd, e, lat);
    checks++; if (rd !== 32'h0000_0011) $display("FAIL byte_rd_lane3 got %h want 00000011", rd); else passes++;
    access(1'b0, 1'b1, 32'h0000_0405, 32'h0, rd, e, lat);
    checks++; if (rd !== 32'h0000_00AA || e !== 1'b0)
      $display("FAIL byte_rd_lane1 got %h err=%b want 000000aa err=0", rd, e); else passes++;
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic e; int lat;
    access(1'b0, 1'b0, 32'h0000_0402, 32'h0, rd, e, lat);
    checks++; if (e !== 1'b1) $display("FAIL misalign_rd_err got %b want 1", e); else passes++;
    checks++; if (rd !== 32'h0) $display("FAIL misalign_rd_data got %h want 00000000", rd); else passes++;
    checks++; if (lat !== 3) $display("FAIL misalign_latency got %0d want 3", lat); else passes++;
    access(1'b1, 1'b0, 32'h0000_0402, 32'hFFFF_FFFF, rd, e, lat);
    checks++; if (e !== 1'b1) $display("FAIL misalign_wr_err got %b want 1", e); else passes++;
    access(1'b0, 1'b0, 32'h0000_0400, 32'h0, rd, e, lat);
    checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL misalign_no_write got %h want deadbeef", rd); else passes++;
  endtask

  task automatic test_range();
    logic [31:0] rd; logic e; int lat;
    access(1'b0, 1'b0, 32'h0000_03FC, 32'h0, rd, e, lat);
    checks++; if (e !== 1'b1 || rd !== 32'h0)
      $display("FAIL below_base got err=%b data=%h want err=1 data=00000000", e, rd); else passes++;
    access(1'b0, 1'b0, 32'h0000_1400, 32'h0, rd, e, lat);
    checks++; if (e !== 1'b1) $display("FAIL past_end got %b want 1", e); else passes++;
    access(1'b0, 1'b1, 32'h0000_1400, 32'h0, rd, e, lat);
    checks++; if (e !== 1'b1) $display("FAIL past_end_byte got %b want 1", e); else passes++;
    access(1'b1, 1'b0, 32'h0000_13FC, 32'h5A5A_0F0F, rd, e, lat);
    access(1'b0, 1'b0, 32'h0000_13FC, 32'h0, rd, e, lat);
    checks++; if (e !== 1'b0 || rd !== 32'h5A5A_0F0F)
      $display("FAIL last_word got err=%b data=%h want err=0 data=5a5a0f0f", e, rd); else passes++;
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic e; int lat; int acks;
    access(1'b1, 1'b0, 32'h0000_0408, 32'h1111_1111, rd, e, lat);
    req = 1'b1; we = 1'b1; bt = 1'b0; addr = 32'h0000_0408; wdata = 32'h1234_5678;
    @(posedge clk); #1;   // sampled, counter 2
    req = 1'b0;
    @(posedge clk); #1;   // counter 1
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passes++;
    checks++; if (rdata !== 32'h0) $display("FAIL abort_rdata got %h want 00000000", rdata); else passes++;
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
    end
    checks++; if (acks !== 0) $display("FAIL abort_no_ack got %0d want 0", acks); else passes++;
    access(1'b0, 1'b0, 32'h0000_0408, 32'h0, rd, e, lat);
    checks++; if (rd !== 32'h1111_1111) $display("FAIL abort_no_write got %h want 11111111", rd); else passes++;
  endtask

  task automatic test_busy_ignore();
    int acks;
    req = 1'b1; we = 1'b0; bt = 1'b0; addr = 32'h0000_0408; wdata = 32'h0;
    @(posedge clk); #1;   // sampling edge
    acks = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
      if (i == 4) req = 1'b0;   // held through every busy edge, dropped once idle
    end
    checks++; if (acks !== 1) $display("FAIL busy_ignore got %0d acks want 1", acks); else passes++;
  endtask

  task automatic test_back_to_back();
    int lat; int acks; int first; int last;
    req0 = 1'b1; we0 = 1'b1; bt0 = 1'b0; addr0 = 32'h0000_0400; wdata0 = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req0 = 1'b0;
    lat = 0;
    while (ack0 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 1) $display("FAIL ws0_latency got %0d want 1", lat); else passes++;
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0;
    acks = 0; first = -1; last = -1;
    for (int i = 0; i <= 12; i++) begin
      @(posedge clk); #1;
      if (ack0 === 1'b1) begin
        acks++;
        if (first < 0) first = i;
        last = i;
      end
      if (i == 8) req0 = 1'b0;
    end
    checks++; if (acks !== 3) $display("FAIL ws0_ack_count got %0d want 3", acks); else passes++;
    checks++; if (first !== 1 || last !== 7)
      $display("FAIL ws0_ack_spacing got first=%0d last=%0d want 1 7", first, last); else passes++;
    checks++; if (rdata0 !== 32'hCAFE_F00D) $display("FAIL ws0_rdata got %h want cafef00d", rdata0); else passes++;
  endtask

  initial begin
    #1;
    test_reset();
    test_word_rw();
    test_byte();
    test_misaligned();
    test_range();
    test_reset_abort();
    test_busy_ignore();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
